// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width, line idle level.
// Used by uart_rx_byte today and by the transmit side downstream of the cipher.
package uart_pkg;

   localparam int   DATA_BITS  = 8;
   localparam logic IDLE_LEVEL = 1'b1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      BREAK  = 3'd5
   } uart_state_t;

   // Even parity bit for a data word: the bit that makes the total count of ones even.
   function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_rx_byte_if.sv
// Byte-side handshake of the UART receiver: data/valid/ready plus error pulses.
interface uart_rx_byte_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 frame_err;
   logic                 overrun;

   modport master (output rx_data, rx_valid, frame_err, overrun, input rx_ready);
   modport slave  (input rx_data, rx_valid, frame_err, overrun, output rx_ready);

endinterface

// File: rtl/uart_sync.sv
// Flop-chain synchronizer for an asynchronous input; resets to 1 so an idle
// high line does not look like an edge coming out of reset.
module uart_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] chain;

   // Shift the raw input through the chain, oldest sample at the top bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) chain <= {SYNC_STAGES{1'b1}};
      else        chain <= {chain[SYNC_STAGES-2:0], d};
   end

   assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_byte.sv
// UART byte receiver (8N1, LSB first) with a single holding register on a
// valid/ready handshake, framing-error and overrun pulses.
// Optional: define UART_RX_PARITY_EN for 8E1 frames (adds a PARITY state).
//
// state  | meaning
// IDLE   | line idle, waiting for rxs low
// START  | timing to mid start bit, rejecting glitches
// DATA   | sampling 8 data bits at bit-period intervals
// PARITY | sampling the even-parity bit (parity build only)
// STOP   | sampling the stop bit; commit or flag the byte
// BREAK  | line held low after a bad stop, waiting for it to go high
module uart_rx_byte
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 10417,
   parameter int SYNC_STAGES  = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           ena,
   input  logic           serial_in,
   uart_rx_byte_if.master rx
);

   localparam int           CW      = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
   localparam logic [2:0]    LAST_IX = 3'(DATA_BITS - 1);

   uart_state_t          state, state_nx;
   logic [CW-1:0]        cnt;
   logic [2:0]           bit_idx;
   logic [DATA_BITS-1:0] shift_reg;
   logic                 rxs;

   logic                 at_half, at_full;
   logic                 cnt_clr, shift_en, stop_smp, par_ok;
   logic                 commit_good, frame_bad;

   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q, ferr_q, ovr_q;

`ifdef UART_RX_PARITY_EN
   logic                 par_bit;
   logic                 par_en;
`endif

   uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (serial_in),
      .q     (rxs)
   );

   assign at_half = (cnt == HALF_TC);
   assign at_full = (cnt == FULL_TC);

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state logic; ena low forces IDLE from anywhere.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:   if (rxs != IDLE_LEVEL) state_nx = START;
         START:  if (at_half) state_nx = (rxs == IDLE_LEVEL) ? IDLE : DATA;
         DATA: begin
            if (at_full && (bit_idx == LAST_IX)) begin
`ifdef UART_RX_PARITY_EN
               state_nx = PARITY;
`else
               state_nx = STOP;
`endif
            end
         end
         PARITY: if (at_full) state_nx = STOP;
         STOP:   if (at_full) state_nx = (rxs == IDLE_LEVEL) ? IDLE : BREAK;
         BREAK:  if (rxs == IDLE_LEVEL) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (!ena) state_nx = IDLE;
   end

   // Per-state controls: sample strobes, counter clear, commit/error decisions.
   always_comb begin
      cnt_clr  = (state_nx != state) || at_full || (state == IDLE) || (state == BREAK);
      shift_en = ena && (state == DATA) && at_full;
      stop_smp = ena && (state == STOP) && at_full;
`ifdef UART_RX_PARITY_EN
      par_en   = ena && (state == PARITY) && at_full;
      par_ok   = (par_bit == even_parity(shift_reg));
`else
      par_ok   = 1'b1;
`endif
      commit_good = stop_smp && (rxs == IDLE_LEVEL) && par_ok;
      frame_bad   = stop_smp && !((rxs == IDLE_LEVEL) && par_ok);
   end

   // Bit-period counter, restarted on every state entry and at each sample point.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       cnt <= '0;
      else if (cnt_clr) cnt <= '0;
      else              cnt <= cnt + CW'(1);
   end

   // Data deserializer: bit index restarts whenever we are outside DATA.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_idx   <= '0;
         shift_reg <= '0;
      end else begin
         if (state != DATA) bit_idx <= '0;
         else if (shift_en) bit_idx <= bit_idx + 3'd1;
         if (shift_en) shift_reg[bit_idx] <= rxs;
      end
   end

`ifdef UART_RX_PARITY_EN
   // Captured parity bit, checked against the data at the stop sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      par_bit <= 1'b0;
      else if (par_en) par_bit <= rxs;
   end
`endif

   // Holding register and handshake; a commit into a full, undrained register is dropped.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ferr_q <= frame_bad;
         ovr_q  <= 1'b0;
         if (commit_good) begin
            if (!valid_q || rx.rx_ready) begin
               data_q  <= shift_reg;
               valid_q <= 1'b1;
            end else begin
               ovr_q <= 1'b1;
            end
         end else if (valid_q && rx.rx_ready) begin
            valid_q <= 1'b0;
         end
      end
   end

   assign rx.rx_data   = data_q;
   assign rx.rx_valid  = valid_q;
   assign rx.frame_err = ferr_q;
   assign rx.overrun   = ovr_q;

endmodule
